// File: rtl/i2c_slave_regfile_ctrl.sv
// i2c_slave_regfile_ctrl
// Pointer-protocol sequencer between the I2C slave byte streams and a simple
// synchronous register bus. The first byte of a write sets the register
// pointer; later write bytes land at the pointer. Read bytes are served from
// a prefetched copy of the register at the pointer, so the slave never waits
// on register latency. The pointer optionally auto-increments.
module i2c_slave_regfile_ctrl #(
  parameter int PTR_WIDTH = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_rx_tdata,
  input  logic                 s_axis_rx_tvalid,
  output logic                 s_axis_rx_tready,
  input  logic                 s_axis_rx_tlast,
  output logic [7:0]           m_axis_tx_tdata,
  output logic                 m_axis_tx_tvalid,
  input  logic                 m_axis_tx_tready,
  output logic                 m_axis_tx_tlast,
  input  logic                 bus_addressed,
  output logic [PTR_WIDTH-1:0] reg_addr,
  output logic [7:0]           reg_wr_data,
  output logic                 reg_wr_en,
  output logic                 reg_rd_en,
  input  logic [7:0]           reg_rd_data,
  output logic [PTR_WIDTH-1:0] ptr,
  output logic                 busy
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] READY   = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;

  localparam logic [PTR_WIDTH-1:0] PTR_STEP = (AUTO_INC != 0) ? PTR_WIDTH'(1) : '0;

  logic [1:0]           state;
  logic                 expect_ptr;
  logic                 addressed_q;
  logic                 addr_rise;
  logic                 rx_hs;
  logic                 tx_hs;
  logic                 ptr_clear;
  logic [PTR_WIDTH-1:0] ptr_next;
  logic [PTR_WIDTH-1:0] ptr_byte;
  logic                 unused_tlast;

  // Pointer arithmetic wraps naturally modulo 2^PTR_WIDTH.
  function automatic logic [PTR_WIDTH-1:0] ptr_advance(input logic [PTR_WIDTH-1:0] p);
    return p + PTR_STEP;
  endfunction

  assign ptr_next  = ptr_advance(ptr);
  assign ptr_byte  = s_axis_rx_tdata[PTR_WIDTH-1:0];
  assign addr_rise = bus_addressed && !addressed_q;

  // Handshake-facing controls decode straight from state and are forced low
  // while reset is held, so a reset landing in WRITE drops the strobe at once.
  assign m_axis_tx_tvalid = !rst && (state == READY);
  assign s_axis_rx_tready = !rst && (state == READY) && !m_axis_tx_tready;
  assign reg_rd_en        = !rst && (state == FETCH);
  assign reg_wr_en        = !rst && (state == WRITE);
  assign busy             = rst || (state != READY);
  assign m_axis_tx_tlast  = 1'b0;

  // rx_tready excludes tx_tready, so at most one of these fires per cycle.
  assign rx_hs     = s_axis_rx_tvalid && s_axis_rx_tready;
  assign tx_hs     = m_axis_tx_tvalid && m_axis_tx_tready;
  assign ptr_clear = rx_hs && expect_ptr;

  assign unused_tlast = s_axis_rx_tlast;

  // Sequencer: prefetch at pointer, hold byte in READY, service rx/tx, refetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      ptr             <= '0;
      reg_addr        <= '0;
      reg_wr_data     <= '0;
      m_axis_tx_tdata <= '0;
    end else begin
      case (state)
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          m_axis_tx_tdata <= reg_rd_data;
          state           <= READY;
        end
        READY: begin
          if (rx_hs) begin
            if (expect_ptr) begin
              ptr      <= ptr_byte;
              reg_addr <= ptr_byte;
              state    <= FETCH;
            end else begin
              reg_addr    <= ptr;
              reg_wr_data <= s_axis_rx_tdata;
              ptr         <= ptr_next;
              state       <= WRITE;
            end
          end else if (tx_hs) begin
            ptr      <= ptr_next;
            reg_addr <= ptr_next;
            state    <= FETCH;
          end
        end
        default: begin
          // WRITE: strobe issued this cycle; point the bus back at ptr and refetch.
          reg_addr <= ptr;
          state    <= FETCH;
        end
      endcase
    end
  end

  // Pointer-byte expectation: armed on each new addressing, cleared by a pointer byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      addressed_q <= 1'b0;
      expect_ptr  <= 1'b0;
    end else begin
      addressed_q <= bus_addressed;
      if (addr_rise) begin
        expect_ptr <= 1'b1;
      end else if (ptr_clear) begin
        expect_ptr <= 1'b0;
      end
    end
  end

endmodule
